// File: rtl/fc_tiled_engine.sv
`default_nettype none
// ============================================================================
// Module  : fc_tiled_engine
// Brief   : Tiled fully-connected layer engine, NUM_PE output nodes per tile,
//           shift/ReLU/saturate requantisation, valid/ready result stream.
// Revision: 1.0
// ============================================================================
module fc_tiled_engine #(
  parameter int NUM_PE  = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int MAX_IN  = 128,
  parameter int MAX_OUT = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [$clog2(MAX_IN):0]    in_node_num_i,
  input  logic [$clog2(MAX_OUT):0]   out_node_num_i,
  input  logic [4:0]                 shift_i,
  input  logic                       relu_en_i,
  input  logic                       wbuf_wren_i,
  input  logic [$clog2(MAX_OUT)-1:0] wbuf_wout_i,
  input  logic [$clog2(MAX_IN)-1:0]  wbuf_win_i,
  input  logic [DATA_W-1:0]          wbuf_wdata_i,
  input  logic                       ifmap_wren_i,
  input  logic [$clog2(MAX_IN)-1:0]  ifmap_waddr_i,
  input  logic [DATA_W-1:0]          ifmap_wdata_i,
  output logic [DATA_W-1:0]          psum_o,
  output logic [$clog2(MAX_OUT)-1:0] idx_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int IA_W   = $clog2(MAX_IN);
  localparam int OA_W   = $clog2(MAX_OUT);
  localparam int IN_CW  = IA_W + 1;
  localparam int OUT_CW = OA_W + 1;
  localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int NODE_W = $clog2(MAX_OUT + NUM_PE) + 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                input logic [4:0]               sh,
                                                input logic                     relu);
    logic signed [ACC_W-1:0] s;
    s = a >>> sh;
    if (relu && s[ACC_W-1]) s = '0;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[DATA_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [IA_W-1:0]         k_q, k_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [NODE_W-1:0]       base_q, base_d;
  logic [IN_CW-1:0]        in_num_q, in_num_d;
  logic [OUT_CW-1:0]       out_num_q, out_num_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic signed [ACC_W-1:0] acc_q [NUM_PE];
  logic signed [ACC_W-1:0] acc_d [NUM_PE];
  logic [DATA_W-1:0]       psum_q, psum_d;
  logic [OA_W-1:0]         idx_q, idx_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic signed [DATA_W-1:0] wbuf_mem  [MAX_OUT][MAX_IN];
  logic signed [DATA_W-1:0] ifmap_mem [MAX_IN];
  logic signed [DATA_W-1:0] x_cur;
  logic signed [ACC_W-1:0]  prod_ext [NUM_PE];
  logic [NODE_W-1:0]        node_cur, node_d;
  logic                     counts_ok, k_last, node_last;

  // Buffers are only writable while idle so a running layer sees stable data.
  always_ff @(posedge clk) begin
    if (wbuf_wren_i && (state_q == S_IDLE))
      wbuf_mem[wbuf_wout_i][wbuf_win_i] <= wbuf_wdata_i;
    if (ifmap_wren_i && (state_q == S_IDLE))
      ifmap_mem[ifmap_waddr_i] <= ifmap_wdata_i;
  end

  assign x_cur = ifmap_mem[k_q];

  for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
    logic [NODE_W-1:0]        row;
    logic signed [DATA_W-1:0] w;
    logic signed [PROD_W-1:0] prod;
    assign row  = base_q + NODE_W'(p);
    // Rows past the buffer belong to skipped lanes; feed zero instead.
    assign w    = (row < NODE_W'(MAX_OUT)) ? wbuf_mem[row[OA_W-1:0]][k_q] : '0;
    assign prod = w * x_cur;
    assign prod_ext[p] = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  assign counts_ok = (in_node_num_i != '0) && (in_node_num_i <= IN_CW'(MAX_IN)) &&
                     (out_node_num_i != '0) && (out_node_num_i <= OUT_CW'(MAX_OUT));
  assign k_last    = ({1'b0, k_q} == (in_num_q - IN_CW'(1)));
  assign node_cur  = base_q + NODE_W'(lane_q);
  assign node_last = (node_cur == (NODE_W'(out_num_q) - NODE_W'(1)));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lane_d    = lane_q;
    base_d    = base_q;
    in_num_d  = in_num_q;
    out_num_d = out_num_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    err_d     = 1'b0;
    for (int p = 0; p < NUM_PE; p++) acc_d[p] = acc_q[p];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (counts_ok) begin
            in_num_d  = in_node_num_i;
            out_num_d = out_node_num_i;
            shift_d   = shift_i;
            relu_d    = relu_en_i;
            base_d    = '0;
            k_d       = '0;
            lane_d    = '0;
            for (int p = 0; p < NUM_PE; p++) acc_d[p] = '0;
            state_d   = S_COMPUTE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        for (int p = 0; p < NUM_PE; p++) acc_d[p] = acc_q[p] + prod_ext[p];
        if (k_last) begin
          lane_d  = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + IA_W'(1);
        end
      end
      S_DRAIN: begin
        if (ready_i) begin
          if (node_last) begin
            state_d = S_DONE;
          end else if (lane_q == LANE_W'(NUM_PE - 1)) begin
            for (int p = 0; p < NUM_PE; p++) acc_d[p] = '0;
            base_d  = base_q + NODE_W'(NUM_PE);
            k_d     = '0;
            lane_d  = '0;
            state_d = S_COMPUTE;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from next-state values so they are true flops.
    node_d  = base_d + NODE_W'(lane_d);
    valid_d = (state_d == S_DRAIN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    last_d  = valid_d && (node_d == (NODE_W'(out_num_d) - NODE_W'(1)));
    psum_d  = valid_d ? requant(acc_d[lane_d], shift_d, relu_d) : '0;
    idx_d   = valid_d ? node_d[OA_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      lane_q    <= '0;
      base_q    <= '0;
      in_num_q  <= '0;
      out_num_q <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      for (int p = 0; p < NUM_PE; p++) acc_q[p] <= '0;
      psum_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lane_q    <= lane_d;
      base_q    <= base_d;
      in_num_q  <= in_num_d;
      out_num_q <= out_num_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      for (int p = 0; p < NUM_PE; p++) acc_q[p] <= acc_d[p];
      psum_q    <= psum_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign psum_o  = psum_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_tiled_engine.sv
`default_nettype none
// Scoreboard bench for fc_tiled_engine: stimulus pushes expected nodes,
// a negedge monitor pops and compares them on every handshake.
module tb_fc_tiled_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] in_node_num_i;
  logic [7:0] out_node_num_i;
  logic [4:0] shift_i;
  logic       relu_en_i;
  logic       wbuf_wren_i;
  logic [6:0] wbuf_wout_i;
  logic [6:0] wbuf_win_i;
  logic [7:0] wbuf_wdata_i;
  logic       ifmap_wren_i;
  logic [6:0] ifmap_waddr_i;
  logic [7:0] ifmap_wdata_i;
  logic [7:0] psum_o;
  logic [6:0] idx_o;
  logic       valid_o;
  logic       ready_i;
  logic       last_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  always #5 clk = ~clk;

  fc_tiled_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .in_node_num_i(in_node_num_i), .out_node_num_i(out_node_num_i),
    .shift_i(shift_i), .relu_en_i(relu_en_i),
    .wbuf_wren_i(wbuf_wren_i), .wbuf_wout_i(wbuf_wout_i), .wbuf_win_i(wbuf_win_i),
    .wbuf_wdata_i(wbuf_wdata_i),
    .ifmap_wren_i(ifmap_wren_i), .ifmap_waddr_i(ifmap_waddr_i), .ifmap_wdata_i(ifmap_wdata_i),
    .psum_o(psum_o), .idx_o(idx_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    int idx;
    int psum;
    int last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic push(input int idx, input int psum, input int last);
    exp_t e;
    e.idx = idx; e.psum = psum; e.last = last;
    sb.push_back(e);
  endtask

  // Monitor: compare on handshake, watch hold under backpressure and done timing
  logic expect_done = 1'b0;
  logic hold_pend   = 1'b0;
  int   hold_psum, hold_idx;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expect_done = 1'b0;
      hold_pend   = 1'b0;
    end else begin
      if (expect_done) begin
        check("done_after_last", int'(done_o), 1);
        expect_done = 1'b0;
      end
      if (hold_pend) begin
        check("hold_valid", int'(valid_o), 1);
        check("hold_psum", $signed(psum_o), hold_psum);
        check("hold_idx", int'(idx_o), hold_idx);
        hold_pend = 1'b0;
      end
      if (valid_o && !ready_i) begin
        hold_pend = 1'b1;
        hold_psum = $signed(psum_o);
        hold_idx  = int'(idx_o);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_output_idx", int'(idx_o), -1);
        end else begin
          e = sb.pop_front();
          check("psum", $signed(psum_o), e.psum);
          check("idx", int'(idx_o), e.idx);
          check("last", int'(last_o), e.last);
          if (last_o) expect_done = 1'b1;
        end
      end
    end
  end

  task automatic write_w(input int r, input int c, input int v);
    wbuf_wren_i = 1'b1; wbuf_wout_i = 7'(r); wbuf_win_i = 7'(c); wbuf_wdata_i = 8'(v);
    @(posedge clk); #1;
    wbuf_wren_i = 1'b0;
  endtask

  task automatic write_x(input int a, input int v);
    ifmap_wren_i = 1'b1; ifmap_waddr_i = 7'(a); ifmap_wdata_i = 8'(v);
    @(posedge clk); #1;
    ifmap_wren_i = 1'b0;
  endtask

  task automatic load_basic();
    write_x(0, 1); write_x(1, 2); write_x(2, 3);
    write_w(0, 0, 1); write_w(0, 1, 1);  write_w(0, 2, 1);
    write_w(1, 0, 2); write_w(1, 1, -1); write_w(1, 2, 0);
  endtask

  task automatic start_layer(input int n_in, input int n_out, input int sh, input int relu);
    in_node_num_i = 8'(n_in); out_node_num_i = 8'(n_out);
    shift_i = 5'(sh); relu_en_i = 1'(relu);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge clk); #1;
      if (done_o) found = 1'b1;
    end
    check("done_seen", int'(found), 1);
    check("scoreboard_drained", sb.size(), 0);
    @(posedge clk); #1;
    check("idle_after_done", int'(busy_o), 0);
  endtask

  task automatic wait_idx(input int idx);
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge clk); #1;
      if (valid_o && int'(idx_o) == idx) found = 1'b1;
    end
    check("wait_idx_seen", int'(found), 1);
  endtask

  task automatic requant_case(input int w, input int sh, input int relu, input int exp_v);
    write_x(0, 127);
    write_w(0, 0, w);
    push(0, exp_v, 1);
    start_layer(1, 1, sh, relu);
    wait_done();
  endtask

  initial begin
    int n, gap;
    bit seen3;
    rst = 1'b1; start_i = 1'b0; in_node_num_i = '0; out_node_num_i = '0;
    shift_i = '0; relu_en_i = 1'b0; wbuf_wren_i = 1'b0; wbuf_wout_i = '0;
    wbuf_win_i = '0; wbuf_wdata_i = '0; ifmap_wren_i = 1'b0; ifmap_waddr_i = '0;
    ifmap_wdata_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", int'(valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_last", int'(last_o), 0);
    check("rst_psum", int'(psum_o), 0);
    check("rst_idx", int'(idx_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: 1+2+3 = 6 and 2-2+0 = 0, first valid 3 edges after start edge
    load_basic();
    push(0, 6, 0); push(1, 0, 1);
    start_layer(3, 2, 0, 0);
    check("busy_in_compute", int'(busy_o), 1);
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      n++;
      if (valid_o) break;
    end
    check("first_valid_latency", n, 3);
    wait_done();

    // Tiling: row r = [r,r], ifmap [1,1] -> 2r, two-tile layer
    write_x(0, 1); write_x(1, 1);
    for (int r = 0; r < 6; r++) begin
      write_w(r, 0, r); write_w(r, 1, r);
      push(r, 2 * r, (r == 5) ? 1 : 0);
    end
    start_layer(2, 6, 0, 0);
    gap = 0; seen3 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (valid_o && idx_o == 7'd3) seen3 = 1'b1;
      else if (seen3 && !valid_o) gap++;
      else if (seen3 && valid_o && idx_o == 7'd4) break;
    end
    check("tile_gap_cycles", gap, 2);
    wait_done();

    // Backpressure on idx1
    load_basic();
    push(0, 6, 0); push(1, 0, 1);
    start_layer(3, 2, 0, 0);
    wait_idx(1);
    ready_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ready_i = 1'b1;
    wait_done();

    // Requantisation: 127*127 = 16129
    requant_case(127, 7, 0, 126);
    requant_case(127, 0, 0, 127);
    requant_case(-127, 0, 1, 0);
    requant_case(-127, 0, 0, -128);

    // Illegal counts
    start_layer(0, 2, 0, 0);
    check("err_in0", int'(err_o), 1);
    check("err_in0_busy", int'(busy_o), 0);
    @(posedge clk); #1;
    check("err_pulse_ends", int'(err_o), 0);
    check("err_in0_busy_after", int'(busy_o), 0);
    start_layer(3, 129, 0, 0);
    check("err_out129", int'(err_o), 1);
    check("err_out129_busy", int'(busy_o), 0);

    // Writes and start during COMPUTE are ignored
    load_basic();
    push(0, 6, 0); push(1, 0, 1);
    start_layer(3, 2, 0, 0);
    wbuf_wren_i = 1'b1; wbuf_wout_i = 7'd0; wbuf_win_i = 7'd0; wbuf_wdata_i = 8'd100;
    ifmap_wren_i = 1'b1; ifmap_waddr_i = 7'd0; ifmap_wdata_i = 8'd50;
    start_i = 1'b1; in_node_num_i = 8'd1; out_node_num_i = 8'd1;
    @(posedge clk); #1;
    wbuf_wren_i = 1'b0; ifmap_wren_i = 1'b0; start_i = 1'b0;
    wait_done();
    push(0, 6, 0); push(1, 0, 1);
    start_layer(3, 2, 0, 0);
    wait_done();

    // Reset during DRAIN, then a fresh layer with new buffers
    load_basic();
    push(0, 6, 0); push(1, 0, 1);
    start_layer(3, 2, 0, 0);
    wait_idx(1);
    rst = 1'b1;
    #1;
    check("rstmid_valid", int'(valid_o), 0);
    check("rstmid_busy", int'(busy_o), 0);
    check("rstmid_last", int'(last_o), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // ifmap [2,0,-1]; row0 [3,5,4] -> 2; row1 [-1,7,2] -> -4
    write_x(0, 2); write_x(1, 0); write_x(2, -1);
    write_w(0, 0, 3);  write_w(0, 1, 5); write_w(0, 2, 4);
    write_w(1, 0, -1); write_w(1, 1, 7); write_w(1, 2, 2);
    push(0, 2, 0); push(1, -4, 1);
    start_layer(3, 2, 0, 0);
    wait_done();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
